// File: rtl/twgen.sv
// FFT twiddle-factor generator: quarter-wave cosine table with quadrant folding,
// fed either by single-index requests or by an internal strided sweep sequencer.
module twgen #(
  parameter int LOG2N = 10,
  parameter int DW    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 twact,
  input  logic [LOG2N-1:0]     twa,
  input  logic                 inv,
  input  logic                 seq_start,
  input  logic [LOG2N-1:0]     seq_base,
  input  logic [LOG2N-1:0]     seq_stride,
  input  logic [LOG2N:0]       seq_len,
  output logic                 busy,
  output logic [DW-1:0]        twdr_cos,
  output logic [DW-1:0]        twdr_sin,
  output logic                 twvld,
  output logic                 twlast
);

  localparam int N  = 1 << LOG2N;
  localparam int QW = LOG2N - 2;
  localparam int Q  = 1 << QW;

  // Elaboration-time cosine (Taylor series), truncated toward zero.
  function automatic logic signed [DW-1:0] cos_entry(input int j);
    real x, term, sum, amp;
    amp  = real'((64'd1 << (DW - 1)) - 64'd1);
    x    = 2.0 * 3.14159265358979323846 * real'(j) / real'(N);
    term = 1.0;
    sum  = 1.0;
    for (int k = 1; k <= 12; k++) begin
      term = -term * x * x / real'((2 * k - 1) * (2 * k));
      sum  = sum + term;
    end
    return DW'($rtoi(amp * sum));
  endfunction

  logic signed [DW-1:0] tab_s [Q];
  for (genvar j = 0; j < Q; j++) begin : g_tab
    localparam logic signed [DW-1:0] CV = cos_entry(j);
    assign tab_s[j] = CV;
  end

  typedef enum logic {IDLE = 1'b0, SWEEP = 1'b1} state_e;

  state_e             state_q, state_d;
  logic [LOG2N-1:0]   acc_q, acc_d, stride_q, stride_d;
  logic [LOG2N:0]     cnt_q, cnt_d;
  logic               iss_v_s, iss_last_s;
  logic [LOG2N-1:0]   iss_idx_s;

  // Sequencer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      stride_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      stride_q <= stride_d;
      cnt_q    <= cnt_d;
    end
  end

  // Sequencer next state; the accumulator wraps modulo N by its width.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    stride_d = stride_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (seq_start && (seq_len != '0)) begin
          state_d  = SWEEP;
          acc_d    = seq_base;
          stride_d = seq_stride;
          cnt_d    = seq_len;
        end else begin
          state_d  = IDLE;
        end
      end
      SWEEP: begin
        acc_d = acc_q + stride_q;
        cnt_d = cnt_q - (LOG2N+1)'(1);
        if (cnt_q == (LOG2N+1)'(1)) state_d = IDLE;
        else                        state_d = SWEEP;
      end
      default: state_d = IDLE;
    endcase
  end

  // Sequencer outputs: index source selection; seq_start beats twact in IDLE.
  always_comb begin
    busy       = (state_q == SWEEP);
    iss_v_s    = 1'b0;
    iss_idx_s  = twa;
    iss_last_s = 1'b0;
    if (state_q == SWEEP) begin
      iss_v_s    = 1'b1;
      iss_idx_s  = acc_q;
      iss_last_s = (cnt_q == (LOG2N+1)'(1));
    end else begin
      iss_v_s    = twact && !seq_start;
    end
  end

  logic                 i_v_q, i_inv_q, i_last_q;
  logic [LOG2N-1:0]     i_idx_q;
  logic                 v1_q, rz1_q, inv1_q, last1_q;
  logic [1:0]           q1_q, q2_q;
  logic [QW-1:0]        ac1_q, as1_q;
  logic                 v2_q, inv2_q, last2_q;
  logic signed [DW-1:0] c2_q, s2_q, c3_s, s3_s;

  // Issue register followed by fold, table read and sign/swap stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_v_q <= 1'b0; i_inv_q <= 1'b0; i_last_q <= 1'b0; i_idx_q <= '0;
      v1_q <= 1'b0; rz1_q <= 1'b0; inv1_q <= 1'b0; last1_q <= 1'b0;
      q1_q <= 2'd0; ac1_q <= '0; as1_q <= '0;
      v2_q <= 1'b0; inv2_q <= 1'b0; last2_q <= 1'b0; q2_q <= 2'd0;
      c2_q <= '0; s2_q <= '0;
      twvld <= 1'b0; twlast <= 1'b0; twdr_cos <= '0; twdr_sin <= '0;
    end else begin
      i_v_q    <= iss_v_s;
      i_idx_q  <= iss_idx_s;
      i_inv_q  <= inv;
      i_last_q <= iss_last_s;
      v1_q     <= i_v_q;
      q1_q     <= i_idx_q[LOG2N-1:LOG2N-2];
      ac1_q    <= i_idx_q[QW-1:0];
      as1_q    <= QW'(0) - i_idx_q[QW-1:0];
      rz1_q    <= (i_idx_q[QW-1:0] == '0);
      inv1_q   <= i_inv_q;
      last1_q  <= i_last_q;
      v2_q     <= v1_q;
      q2_q     <= q1_q;
      inv2_q   <= inv1_q;
      last2_q  <= last1_q;
      c2_q     <= tab_s[ac1_q];
      s2_q     <= rz1_q ? '0 : tab_s[as1_q];
      twvld    <= v2_q;
      twlast   <= v2_q && last2_q;
      if (v2_q) begin
        twdr_cos <= c3_s;
        twdr_sin <= inv2_q ? s3_s : -s3_s;
      end else begin
        twdr_cos <= twdr_cos;
        twdr_sin <= twdr_sin;
      end
    end
  end

  // Quadrant map of the folded (C, S) pair.
  always_comb begin
    c3_s = c2_q;
    s3_s = s2_q;
    case (q2_q)
      2'd0:    begin c3_s =  c2_q; s3_s =  s2_q; end
      2'd1:    begin c3_s = -s2_q; s3_s =  c2_q; end
      2'd2:    begin c3_s = -c2_q; s3_s = -s2_q; end
      2'd3:    begin c3_s =  s2_q; s3_s = -c2_q; end
      default: begin c3_s =  c2_q; s3_s =  s2_q; end
    endcase
  end

endmodule

// File: tb/tb_twgen.sv
// Scoreboard bench for twgen: stimulus pushes expected results with their due
// cycle; a negedge monitor pops and compares every twvld pulse.
module tb_twgen;

  logic               clk = 1'b0;
  logic               rst_n, twact, inv, seq_start;
  logic [9:0]         twa, seq_base, seq_stride;
  logic [10:0]        seq_len;
  logic               busy, twvld, twlast;
  logic [15:0]        twdr_cos, twdr_sin;

  typedef struct {
    logic signed [15:0] c;
    logic signed [15:0] s;
    logic               last;
    int                 due;
  } item_t;

  item_t              sb[$];
  int                 cyc = 0;
  int                 checks = 0;
  int                 errors = 0;
  int                 popped = 0;
  logic signed [15:0] hold_c = 16'sd0;
  logic signed [15:0] hold_s = 16'sd0;

  twgen #(.LOG2N(10), .DW(16)) dut (
    .clk(clk), .rst_n(rst_n), .twact(twact), .twa(twa), .inv(inv),
    .seq_start(seq_start), .seq_base(seq_base), .seq_stride(seq_stride),
    .seq_len(seq_len), .busy(busy), .twdr_cos(twdr_cos), .twdr_sin(twdr_sin),
    .twvld(twvld), .twlast(twlast)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    item_t it;
    if (!rst_n) begin
      hold_c = 16'sd0;
      hold_s = 16'sd0;
      checks++;
      if (busy || twvld || twlast || twdr_cos != 16'd0 || twdr_sin != 16'd0) begin
        errors++;
        $display("FAIL reset_outputs: got busy=%b vld=%b last=%b cos=%0d sin=%0d, want all 0",
                 busy, twvld, twlast, $signed(twdr_cos), $signed(twdr_sin));
      end
    end else if (twvld) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result: cyc=%0d cos=%0d sin=%0d, want no twvld",
                 cyc, $signed(twdr_cos), $signed(twdr_sin));
      end else begin
        it = sb.pop_front();
        popped++;
        hold_c = it.c;
        hold_s = it.s;
        if ($signed(twdr_cos) != it.c || $signed(twdr_sin) != it.s ||
            twlast != it.last || cyc != it.due) begin
          errors++;
          $display("FAIL result: got cos=%0d sin=%0d last=%b cyc=%0d, want cos=%0d sin=%0d last=%b cyc=%0d",
                   $signed(twdr_cos), $signed(twdr_sin), twlast, cyc, it.c, it.s, it.last, it.due);
        end
      end
    end else begin
      checks++;
      if (twlast || $signed(twdr_cos) != hold_c || $signed(twdr_sin) != hold_s) begin
        errors++;
        $display("FAIL hold: got cos=%0d sin=%0d last=%b, want cos=%0d sin=%0d last=0",
                 $signed(twdr_cos), $signed(twdr_sin), twlast, hold_c, hold_s);
      end
    end
  end

  task automatic push(input logic signed [15:0] c, input logic signed [15:0] s,
                      input logic last, input int due);
    item_t it;
    it.c = c; it.s = s; it.last = last; it.due = due;
    sb.push_back(it);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input logic [9:0] a, input logic iv,
                       input logic signed [15:0] c, input logic signed [15:0] s);
    twact = 1'b1; twa = a; inv = iv;
    push(c, s, 1'b0, cyc + 4);
    step();
    twact = 1'b0;
  endtask

  task automatic check_busy(input logic want, input string name);
    checks++;
    if (busy !== want) begin
      errors++;
      $display("FAIL %s: busy=%b, want %b", name, busy, want);
    end
  endtask

  initial begin
    rst_n = 1'b0; twact = 1'b0; inv = 1'b0; seq_start = 1'b0;
    twa = 10'd0; seq_base = 10'd0; seq_stride = 10'd0; seq_len = 11'd0;
    repeat (3) step();
    rst_n = 1'b1;
    repeat (3) step();

    // Single-index lookups; back-to-back issues give consecutive pulses.
    issue(10'd0,   1'b0,  16'sd32767,  16'sd0);
    repeat (4) step();
    issue(10'd256, 1'b0,  16'sd0,     -16'sd32767);
    issue(10'd256, 1'b1,  16'sd0,      16'sd32767);
    issue(10'd128, 1'b0,  16'sd23169, -16'sd23169);
    issue(10'd640, 1'b0, -16'sd23169,  16'sd23169);
    issue(10'd384, 1'b1, -16'sd23169,  16'sd23169);
    issue(10'd768, 1'b1,  16'sd0,     -16'sd32767);
    issue(10'd2,   1'b0,  16'sd32764, -16'sd402);
    repeat (6) step();

    // Wrapping sweep with twact/seq_start held during busy.
    seq_base = 10'd1020; seq_stride = 10'd2; seq_len = 11'd4; seq_start = 1'b1;
    push( 16'sd32757, 16'sd804,  1'b0, cyc + 5);
    push( 16'sd32764, 16'sd402,  1'b0, cyc + 6);
    push( 16'sd32767, 16'sd0,    1'b0, cyc + 7);
    push( 16'sd32764, -16'sd402, 1'b1, cyc + 8);
    step();
    check_busy(1'b1, "busy_after_start");
    twact = 1'b1; twa = 10'd5; seq_base = 10'd7; seq_len = 11'd3;
    for (int i = 0; i < 3; i++) begin
      step();
      check_busy(1'b1, "busy_during_sweep");
    end
    step();
    twact = 1'b0; seq_start = 1'b0;
    check_busy(1'b0, "busy_after_sweep");
    repeat (6) step();

    // Live inv per sweep index; simultaneous twact is dropped.
    seq_base = 10'd0; seq_stride = 10'd256; seq_len = 11'd4; seq_start = 1'b1;
    twact = 1'b1; twa = 10'd100;
    push( 16'sd32767,  16'sd0,     1'b0, cyc + 5);
    push( 16'sd0,      16'sd32767, 1'b0, cyc + 6);
    push(-16'sd32767,  16'sd0,     1'b0, cyc + 7);
    push( 16'sd0,     -16'sd32767, 1'b1, cyc + 8);
    step();
    seq_start = 1'b0; twact = 1'b0;
    for (int i = 0; i < 4; i++) begin
      inv = i[0];
      step();
    end
    inv = 1'b0;
    repeat (6) step();

    // Zero-length sweep does nothing.
    seq_len = 11'd0; seq_start = 1'b1;
    step();
    seq_start = 1'b0;
    check_busy(1'b0, "busy_len0");
    repeat (6) step();

    // Reset after two results of a long sweep.
    seq_base = 10'd0; seq_stride = 10'd1; seq_len = 11'd8; seq_start = 1'b1;
    push(16'sd32767, 16'sd0,    1'b0, cyc + 5);
    push(16'sd32766, -16'sd201, 1'b0, cyc + 6);
    step();
    seq_start = 1'b0;
    begin
      int target = popped + 2;
      bit seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(negedge clk);
        #1;
        if (popped >= target) seen = 1'b1;
      end
      checks++;
      if (!seen) begin
        errors++;
        $display("FAIL sweep_before_reset: results=%0d, want %0d", popped, target);
      end
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy || twvld || twlast || twdr_cos != 16'd0 || twdr_sin != 16'd0) begin
      errors++;
      $display("FAIL async_reset: busy=%b vld=%b cos=%0d sin=%0d, want all 0",
               busy, twvld, $signed(twdr_cos), $signed(twdr_sin));
    end
    sb.delete();
    repeat (2) step();
    rst_n = 1'b1;
    repeat (12) step();
    check_busy(1'b0, "busy_after_reset");

    begin
      int n = 0;
      while (sb.size() != 0 && n < 30) begin
        step();
        n++;
      end
      checks++;
      if (sb.size() != 0) begin
        errors++;
        $display("FAIL drain_timeout: %0d results outstanding, want 0", sb.size());
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/twgen.md
TWGEN -- requirements
Module: twgen

Interface
REQ-001 Parameter LOG2N, default 10, log2 of FFT size N; legal range 3..14.
REQ-002 Parameter DW, default 16, twiddle component width (signed two's complement); legal range 8..18.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 twact  in  1  single-index request strobe; twa sampled when high.
REQ-006 twa  in  LOG2N  full-circle twiddle index k, angle 2*pi*k/N.
REQ-007 inv  in  1  0 = forward twiddle e^(-j2pi k/N); 1 = inverse/conjugate e^(+j2pi k/N); sampled with each issued index.
REQ-008 seq_start  in  1  sweep start strobe; seq_base, seq_stride and seq_len sampled when high.
REQ-009 seq_base  in  LOG2N  first sweep index.
REQ-010 seq_stride  in  LOG2N  sweep index increment.
REQ-011 seq_len  in  LOG2N+1  number of sweep indices, 0..N.
REQ-012 busy  out  1  sweep in progress.
REQ-013 twdr_cos  out  DW  real part, signed.
REQ-014 twdr_sin  out  DW  imaginary part, signed, sign per inv.
REQ-015 twvld  out  1  one-cycle pulse per result.
REQ-016 twlast  out  1  high with twvld on the final result of a sweep.

Function
REQ-017 Internal quarter-wave table of Q = N/4 entries: C[j] = trunc-toward-zero((2^(DW-1)-1)*cos(2*pi*j/N)), j = 0..Q-1; defaults give C[0]=32767, C[N/8]=23169.
REQ-018 Fold: q = k[LOG2N-1:LOG2N-2], r = k mod Q; S(r) = 0 if r==0, else C[Q-r].
REQ-019 Quadrant map (c,s): q0 (C[r], S(r)); q1 (-S(r), C[r]); q2 (-C[r], -S(r)); q3 (S(r), -C[r]); negation exact (-32767 representable, no saturation needed).
REQ-020 Output: twdr_cos = c; twdr_sin = -s if inv==0, +s if inv==1.
REQ-021 Pipeline, 3 registered stages: S1 fold/address plus q, r==0 flag, inv, last flag; S2 two table reads; S3 sign/swap; no backpressure, throughput 1 index/cycle.
REQ-022 Latency: index issued at edge t -> twvld high and outputs updated at edge t+3.
REQ-023 twdr_cos/twdr_sin hold their last value while twvld low.
REQ-024 Sequencer states IDLE, SWEEP; IDLE->SWEEP on seq_start with seq_len!=0; seq_len==0 -> stay IDLE, no output.
REQ-025 On seq_start accepted at edge t: busy=1 from edge t; index i = (seq_base + i*seq_stride) mod N issued at edge t+1+i, i = 0..seq_len-1; busy returns 0 at the edge issuing index seq_len-1; SWEEP->IDLE there.
REQ-026 Index arithmetic wraps modulo N (LOG2N-bit accumulator, carry discarded).
REQ-027 twlast marks only result for i = seq_len-1; twact results never assert twlast.
REQ-028 While busy=1: twact and seq_start ignored.
REQ-029 In IDLE, seq_start and twact in same cycle: seq_start wins, twact dropped.
REQ-030 inv for sweep indices is sampled per issued index (live), not latched at start.

Reset
REQ-031 rst_n low: busy, twvld, twlast, twdr_cos, twdr_sin = 0; all pipeline valid/last flags cleared; sequencer IDLE; effect immediate, asynchronous.
REQ-032 Reset mid-sweep or mid-pipeline: in-flight results discarded; after release no result emitted until a new request.
REQ-033 Table contents constant; not affected by reset.

Verification
REQ-034 Reset: assert rst_n=0 mid-run -> all outputs 0 same cycle; release -> outputs stay 0, twvld 0.
REQ-035 twact, twa=0, inv=0 at edge t -> edge t+3: twvld=1, cos=32767, sin=0; edge t+4: twvld=0, values held.
REQ-036 twa=256: inv=0 -> cos=0, sin=-32767; inv=1 -> cos=0, sin=+32767.
REQ-037 twa=128 -> cos=23169, sin=-23169; twa=640 -> cos=-23169, sin=+23169; back-to-back twact -> consecutive twvld pulses, no gaps.
REQ-038 Sweep base=1020, stride=2, len=4 -> indices 1020,1022,0,2 on 4 consecutive twvld, twlast only on 4th; result for 0 = (32767,0); twact and seq_start during busy produce nothing extra; len=0 -> busy stays 0, no twvld.
REQ-039 rst_n low during sweep (after 2 results) -> busy=0 and twvld=0 immediately; no further results after release.
